// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB4 memory completer:
//   - apb_state_e      : completer FSM states (IDLE / WAIT / RESP)
//   - PPROT_*_BIT      : bit positions inside the APB4 PPROT field
//   - APB_MAX_DATA_W   : widest data bus the lane-merge helper supports
//   - apb_merge_lanes  : byte-lane merge (old word, new word, strobe -> word)
// ---------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_e;

    localparam int PPROT_PRIV_BIT   = 0;
    localparam int PPROT_NONSEC_BIT = 1;
    localparam int PPROT_INSTR_BIT  = 2;

    // The merge helper works on a fixed maximum width; callers zero-extend
    // their word and strobe into it and truncate the result back.
    localparam int APB_MAX_DATA_W = 64;
    localparam int APB_MAX_STRB_W = APB_MAX_DATA_W / 8;

    function automatic logic [APB_MAX_DATA_W-1:0] apb_merge_lanes(
        input logic [APB_MAX_DATA_W-1:0] old_word,
        input logic [APB_MAX_DATA_W-1:0] new_word,
        input logic [APB_MAX_STRB_W-1:0] strb
    );
        logic [APB_MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int lane = 0; lane < APB_MAX_STRB_W; lane++) begin
            if (strb[lane]) begin
                merged[lane*8 +: 8] = new_word[lane*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// ---------------------------------------------------------------------------
// apb_mem_bank
// DEPTH x DATA_W storage array with one byte-enabled synchronous write port
// and one registered read port. The array itself is never reset; only the
// read-data register is.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (read-data register only)
//   wr_en    : commit wr_data into mem[wr_addr] on the lanes set in wr_strb
//   wr_addr  : write word index
//   wr_data  : write word
//   wr_strb  : per-byte write enables
//   rd_en    : capture mem[rd_addr] into rd_data at the next edge
//   rd_addr  : read word index
//   rd_data  : registered read word (holds while rd_en is low)
// ---------------------------------------------------------------------------
module apb_mem_bank
    import apb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    rd_addr,
    output logic [DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] merged_word;
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Read-modify-write of the addressed word so unstrobed lanes keep their value.
    always_comb begin
        merged_word = DATA_W'(apb_merge_lanes(APB_MAX_DATA_W'(mem_q[wr_addr]),
                                              APB_MAX_DATA_W'(wr_data),
                                              APB_MAX_STRB_W'(wr_strb)));
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= merged_word;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/apb_completer_mem.sv
// ---------------------------------------------------------------------------
// apb_completer_mem
// APB4 completer backed by a word-addressed memory. Supports PSTRB byte-lane
// writes, a fixed number of wait states per access and PSLVERR for
// out-of-range addresses or reads issued with a non-zero PSTRB.
// Ports:
//   PCLK     : clock, rising edge
//   PRESETn  : asynchronous active-low reset
//   PSEL     : completer select
//   PENABLE  : access phase
//   PWRITE   : 1 = write, 0 = read
//   PADDR    : word index
//   PWDATA   : write data
//   PSTRB    : byte-lane write enables
//   PPROT    : protection attributes (accepted, not checked)
//   PRDATA   : read data, valid while PREADY=1 on a successful read, else 0
//   PREADY   : transfer completion, decoded from state only
//   PSLVERR  : error response, valid while PREADY=1
// ---------------------------------------------------------------------------
module apb_completer_mem
    import apb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    input  logic [2:0]          PPROT,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    apb_state_e          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic                err_q, err_d;
    logic                pslverr_q, pslverr_d;

    logic                setup_phase;
    logic                in_range;
    logic                setup_err;
    logic                mem_wr_en;
    logic                mem_rd_en;
    logic [IDX_W-1:0]    mem_rd_addr;
    logic [DATA_W-1:0]   mem_rd_data;
    logic                unused_pprot;

    // PPROT carries no behaviour here; non-secure and secure are both accepted.
    assign unused_pprot = ^PPROT;

    assign setup_phase = PSEL && !PENABLE;
    assign in_range    = {1'b0, PADDR} < (ADDR_W+1)'(DEPTH);
    assign setup_err   = !in_range || (!PWRITE && (PSTRB != '0));

    // Next-state logic. The error verdict is decided once at setup and carried
    // in err_q, so attribute changes during the access phase have no effect.
    // With no wait states the setup edge itself enters RESP, so the read port
    // is addressed straight from PADDR in that one case.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        err_d       = err_q;
        pslverr_d   = pslverr_q;
        mem_wr_en   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = addr_q[IDX_W-1:0];

        case (state_q)
            IDLE: begin
                if (setup_phase) begin
                    write_d = PWRITE;
                    addr_d  = PADDR;
                    wdata_d = PWDATA;
                    strb_d  = PSTRB;
                    err_d   = setup_err;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d     = RESP;
                        pslverr_d   = setup_err;
                        mem_rd_en   = !PWRITE && !setup_err;
                        mem_rd_addr = PADDR[IDX_W-1:0];
                    end
                end
            end

            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d   = RESP;
                    pslverr_d = err_q;
                    mem_rd_en = !write_q && !err_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            RESP: begin
                if (!PSEL) begin
                    state_d   = IDLE;
                    pslverr_d = 1'b0;
                end else if (PENABLE) begin
                    state_d   = IDLE;
                    pslverr_d = 1'b0;
                    mem_wr_en = write_q && !err_q;
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                pslverr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            err_q     <= err_d;
            pslverr_q <= pslverr_d;
        end
    end

    apb_mem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .wr_en   (mem_wr_en),
        .wr_addr (addr_q[IDX_W-1:0]),
        .wr_data (wdata_q),
        .wr_strb (strb_q),
        .rd_en   (mem_rd_en),
        .rd_addr (mem_rd_addr),
        .rd_data (mem_rd_data)
    );

    // Outputs are decoded from registers only. PRDATA is forced to zero outside
    // a successful read response so stale bank data never leaks onto the bus.
    assign PREADY  = (state_q == RESP);
    assign PSLVERR = pslverr_q;
    assign PRDATA  = ((state_q == RESP) && !write_q && !pslverr_q) ? mem_rd_data : '0;

endmodule

// File: tb/tb_apb_completer_mem.sv
// ---------------------------------------------------------------------------
// tb_apb_completer_mem
// Three completer instances share one APB bus (separate PSEL each) with
// WAIT_STATES of 0, 3 and 2. A word-level reference memory keyed by instance
// and address predicts every response.
// ---------------------------------------------------------------------------
module tb_apb_completer_mem;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        psel [3];
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    int vectors     = 0;
    int miscompares = 0;
    int wsOf [3]    = '{0, 3, 2};

    logic [31:0] refMem [int];

    always #5 PCLK = ~PCLK;

    apb_completer_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb_completer_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_STATES(3)) dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    apb_completer_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_STATES(2)) dut2 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2])
    );

    // One comparison: counts the vector and reports any miscompare.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idleBus();
        for (int i = 0; i < 3; i++) psel[i] = 1'b0;
        PENABLE = 1'b0;
    endtask

    // Drives one full APB transfer on instance 'which' and reports what came
    // back plus how many access cycles PREADY stayed low. During wait cycles
    // PADDR/PWDATA are scrambled; the completer must use its setup values.
    task automatic applyStimulus(input int which, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 output logic [31:0] rdata, output logic err,
                                 output int waits, output logic done);
        @(negedge PCLK);
        checkOutput("idle_pready", 32'(pready[which]), 32'd0);
        psel[which] = 1'b1;
        PENABLE     = 1'b0;
        PWRITE      = wr;
        PADDR       = addr;
        PWDATA      = data;
        PSTRB       = strb;
        PPROT       = 3'b010;
        @(negedge PCLK);
        PENABLE = 1'b1;
        waits   = 0;
        done    = 1'b0;
        rdata   = '0;
        err     = 1'b0;
        while (!done && waits < 40) begin
            if (pready[which]) begin
                rdata = prdata[which];
                err   = pslverr[which];
                done  = 1'b1;
            end else begin
                waits++;
                PADDR  = $urandom;
                PWDATA = $urandom;
                @(negedge PCLK);
            end
        end
        if (!done) begin
            checkOutput("xfer_timeout", 32'd0, 32'd1);
            idleBus();
        end else begin
            @(negedge PCLK);
            idleBus();
            checkOutput("post_pready", 32'(pready[which]), 32'd0);
            checkOutput("post_prdata", prdata[which], 32'd0);
        end
    endtask

    // Transfer plus reference-model prediction and update.
    task automatic doXfer(input int which, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          output logic [31:0] rdata);
        logic        err;
        logic        done;
        int          waits;
        logic        expErr;
        int          key;
        logic [31:0] word;
        applyStimulus(which, wr, addr, data, strb, rdata, err, waits, done);
        key    = which * 65536 + int'(addr);
        expErr = (addr >= 32'd1024) || (!wr && strb != 4'd0);
        if (done) begin
            checkOutput("wait_cycles", 32'(waits), 32'(wsOf[which]));
            checkOutput("pslverr", 32'(err), 32'(expErr));
            if (!wr) begin
                if (expErr) checkOutput("prdata_on_err", rdata, 32'd0);
                else if (refMem.exists(key)) checkOutput("prdata", rdata, refMem[key]);
            end
        end
        if (wr && !expErr && (refMem.exists(key) || strb == 4'hF)) begin
            word = refMem.exists(key) ? refMem[key] : 32'd0;
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) word[b*8 +: 8] = data[b*8 +: 8];
            end
            refMem[key] = word;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic        wr;
        logic [31:0] a;
        logic [3:0]  s;
        int          w;

        PRESETn = 1'b0;
        idleBus();
        PWRITE = 1'b0;
        PADDR  = '0;
        PWDATA = '0;
        PSTRB  = '0;
        PPROT  = 3'b010;
        repeat (3) @(negedge PCLK);
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset_pready", 32'(pready[i]), 32'd0);
            checkOutput("reset_pslverr", 32'(pslverr[i]), 32'd0);
            checkOutput("reset_prdata", prdata[i], 32'd0);
        end
        PRESETn = 1'b1;

        // Zero wait states: basic write then read.
        doXfer(0, 1'b1, 32'd50, 32'h0000001E, 4'hF, r);
        doXfer(0, 1'b0, 32'd50, 32'd0, 4'h0, r);
        checkOutput("ws0_read50", r, 32'h0000001E);

        // Byte-lane merge.
        doXfer(0, 1'b1, 32'd51, 32'hAABBCCDD, 4'hF, r);
        doXfer(0, 1'b1, 32'd51, 32'h11223344, 4'b0101, r);
        doXfer(0, 1'b0, 32'd51, 32'd0, 4'h0, r);
        checkOutput("lane_merge51", r, 32'hAA22CC44);

        // Errors: read with strobe, out-of-range write, address 0 untouched.
        doXfer(0, 1'b1, 32'd0, 32'h0BADF00D, 4'hF, r);
        doXfer(0, 1'b0, 32'd66, 32'd0, 4'b0001, r);
        doXfer(0, 1'b1, 32'd1024, 32'h000000FF, 4'hF, r);
        doXfer(0, 1'b0, 32'd0, 32'd0, 4'h0, r);
        checkOutput("addr0_intact", r, 32'h0BADF00D);

        // Three wait states.
        doXfer(1, 1'b1, 32'd1000, 32'd540, 4'hF, r);
        doXfer(1, 1'b0, 32'd1000, 32'd0, 4'h0, r);
        checkOutput("ws3_read1000", r, 32'd540);

        // Abort: PSEL dropped in the second WAIT cycle, write must be lost.
        doXfer(2, 1'b1, 32'd70, 32'h12345678, 4'hF, r);
        @(negedge PCLK);
        psel[2] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 32'd70; PWDATA = 32'd80; PSTRB = 4'hF;
        @(negedge PCLK);
        PENABLE = 1'b1;
        checkOutput("abort_wait1_pready", 32'(pready[2]), 32'd0);
        @(negedge PCLK);
        checkOutput("abort_wait2_pready", 32'(pready[2]), 32'd0);
        idleBus();
        @(negedge PCLK);
        checkOutput("abort_pready", 32'(pready[2]), 32'd0);
        checkOutput("abort_pslverr", 32'(pslverr[2]), 32'd0);
        doXfer(2, 1'b0, 32'd70, 32'd0, 4'h0, r);
        checkOutput("abort_read70", r, 32'h12345678);

        // Reset pulse mid-WAIT drops the pending write.
        doXfer(1, 1'b1, 32'd5, 32'hCAFE0005, 4'hF, r);
        @(negedge PCLK);
        psel[1] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 32'd5; PWDATA = 32'h0000DEAD; PSTRB = 4'hF;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        checkOutput("rst_wait_pready", 32'(pready[1]), 32'd0);
        checkOutput("rst_wait_pslverr", 32'(pslverr[1]), 32'd0);
        #1 PRESETn = 1'b1;
        idleBus();
        doXfer(1, 1'b0, 32'd5, 32'd0, 4'h0, r);
        checkOutput("rst_read5", r, 32'hCAFE0005);

        // Reset pulse while an error response is on the bus.
        @(negedge PCLK);
        psel[0] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'd2000; PSTRB = 4'h0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        checkOutput("resp_err_pready", 32'(pready[0]), 32'd1);
        checkOutput("resp_err_pslverr", 32'(pslverr[0]), 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        checkOutput("rst_resp_pready", 32'(pready[0]), 32'd0);
        checkOutput("rst_resp_pslverr", 32'(pslverr[0]), 32'd0);
        #1 PRESETn = 1'b1;
        idleBus();

        // Randomized traffic over a small preloaded window on every instance.
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 16; k++) begin
                doXfer(i, 1'b1, 32'(k), $urandom, 4'hF, r);
            end
        end
        for (int n = 0; n < 80; n++) begin
            w  = int'($urandom_range(0, 2));
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 9) == 0) ? 32'd1024 + $urandom_range(0, 8)
                                             : $urandom_range(0, 15);
            if (wr) s = 4'($urandom_range(0, 15));
            else    s = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            doXfer(w, wr, a, $urandom, s, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
